tpu_task_scheduler: RTL

Parametrised multi-unit TPU task scheduler. Buffers submitted task descriptors in an in-order queue and dispatches each to a free TPU unit permitted by the task's affinity mask, with round-robin unit selection. Tracks every unit with its own FSM and watchdog timer, and returns tagged completions (ok/error/timeout) over a valid/ready port. Sits between the host-facing register/command front end and the array of TPU compute units.

---
 rtl/tpu_task_scheduler.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_task_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_task_scheduler : in-order task queue, round-robin affinity dispatch,
// per-unit watchdog FSMs and tagged round-robin completion port.  Rev 1.0
// ---------------------------------------------------------------------------
module tpu_task_scheduler #(
  parameter int NUM_UNITS   = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int DESC_WIDTH  = 48,
  parameter int TAG_WIDTH   = 8,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           sub_valid,
  output logic                           sub_ready,
  input  logic [DESC_WIDTH-1:0]          sub_desc,
  input  logic [TAG_WIDTH-1:0]           sub_tag,
  input  logic [NUM_UNITS-1:0]           sub_affinity,
  output logic [NUM_UNITS-1:0]           unit_start,
  output logic [DESC_WIDTH-1:0]          unit_desc,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  logic [NUM_UNITS-1:0]           unit_error,
  input  logic [NUM_UNITS-1:0]           unit_busy,
  input  logic [TIMEOUT_W-1:0]           timeout_limit,
  output logic                           cpl_valid,
  input  logic                           cpl_ready,
  output logic [$clog2(NUM_UNITS)-1:0]   cpl_unit,
  output logic [TAG_WIDTH-1:0]           cpl_tag,
  output logic [1:0]                     cpl_status,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic [NUM_UNITS-1:0]           units_active,
  output logic [15:0]                    err_count,
  input  logic                           int_en,
  input  logic                           int_clear,
  output logic                           interrupt
);

  localparam int UW = $clog2(NUM_UNITS);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_RUN  = 2'd1,
    U_CPL  = 2'd2
  } ustate_t;

  // First requester at or above ptr, wrapping modulo NUM_UNITS.
  function automatic logic [UW-1:0] f_rr_pick(input logic [NUM_UNITS-1:0] req,
                                               input logic [UW-1:0] ptr);
    logic [UW-1:0] sel;
    logic [UW-1:0] cand;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      cand = UW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return sel;
  endfunction

  function automatic logic [UW-1:0] f_inc(input logic [UW-1:0] p);
    return (p == UW'(NUM_UNITS - 1)) ? '0 : p + UW'(1);
  endfunction

  logic [DESC_WIDTH-1:0] r_q_desc [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  r_q_tag  [QUEUE_DEPTH];
  logic [NUM_UNITS-1:0]  r_q_aff  [QUEUE_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [UW-1:0]         r_rr_ptr, r_cpl_ptr, r_cpl_lock_unit;
  logic                  r_cpl_lock;
  logic [NUM_UNITS-1:0]  r_unit_start;
  logic [DESC_WIDTH-1:0] r_unit_desc;
  logic [15:0]           r_err_count;
  logic                  r_interrupt;

  ustate_t               r_state      [NUM_UNITS];
  ustate_t               w_state_nxt  [NUM_UNITS];
  logic [1:0]            r_status     [NUM_UNITS];
  logic [1:0]            w_status_nxt [NUM_UNITS];
  logic [TIMEOUT_W-1:0]  r_wdog       [NUM_UNITS];
  logic [TAG_WIDTH-1:0]  r_utag       [NUM_UNITS];

  logic                  w_push, w_disp, w_cpl_hs;
  logic [NUM_UNITS-1:0]  w_head_aff, w_avail, w_match, w_cpl_req;
  logic [UW-1:0]         w_pick, w_cpl_sel;

  assign sub_ready  = (r_count < CW'(QUEUE_DEPTH));
  assign w_push     = sub_valid && sub_ready;
  assign w_head_aff = (r_q_aff[r_rd_ptr] == '0) ? '1 : r_q_aff[r_rd_ptr];

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_avail[i]      = (r_state[i] == U_IDLE) && !unit_busy[i];
      w_cpl_req[i]    = (r_state[i] == U_CPL);
      units_active[i] = (r_state[i] != U_IDLE);
    end
  end

  assign w_match  = w_head_aff & w_avail;
  assign w_disp   = enable && (r_count != '0) && (|w_match);
  assign w_pick   = f_rr_pick(w_match, r_rr_ptr);

  // A stalled completion stays locked so a newly completing unit cannot displace it.
  assign w_cpl_sel = r_cpl_lock ? r_cpl_lock_unit : f_rr_pick(w_cpl_req, r_cpl_ptr);
  assign cpl_valid = |w_cpl_req;
  assign w_cpl_hs  = cpl_valid && cpl_ready;
  assign cpl_unit   = cpl_valid ? w_cpl_sel : '0;
  assign cpl_tag    = cpl_valid ? r_utag[w_cpl_sel] : '0;
  assign cpl_status = cpl_valid ? r_status[w_cpl_sel] : 2'b00;

  assign unit_start  = r_unit_start;
  assign unit_desc   = r_unit_desc;
  assign queue_count = r_count;
  assign err_count   = r_err_count;
  assign interrupt   = r_interrupt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_desc[r_wr_ptr] <= sub_desc;
      r_q_tag[r_wr_ptr]  <= sub_tag;
      r_q_aff[r_wr_ptr]  <= sub_affinity;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rr_ptr     <= '0;
      r_unit_start <= '0;
      r_unit_desc  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_disp) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_rr_ptr    <= f_inc(w_pick);
        r_unit_desc <= r_q_desc[r_rd_ptr];
      end
      case ({w_push, w_disp})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_unit_start <= w_disp ? (NUM_UNITS'(1) << w_pick) : '0;
    end
  end

  // Done/error are ignored during the start pulse; error outranks done, both outrank timeout.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_status_nxt[i] = r_status[i];
      case (r_state[i])
        U_IDLE: if (w_disp && (w_pick == UW'(i))) w_state_nxt[i] = U_RUN;
        U_RUN: begin
          if (!r_unit_start[i] && unit_error[i]) begin
            w_state_nxt[i]  = U_CPL;
            w_status_nxt[i] = 2'b01;
          end else if (!r_unit_start[i] && unit_done[i]) begin
            w_state_nxt[i]  = U_CPL;
            w_status_nxt[i] = 2'b00;
          end else if ((timeout_limit != '0) &&
                       (r_wdog[i] + TIMEOUT_W'(1) == timeout_limit)) begin
            w_state_nxt[i]  = U_CPL;
            w_status_nxt[i] = 2'b10;
          end
        end
        U_CPL: if (w_cpl_hs && (w_cpl_sel == UW'(i))) w_state_nxt[i] = U_IDLE;
        default: w_state_nxt[i] = U_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) r_state[i] <= U_IDLE;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_status[i] <= 2'b00;
        r_wdog[i]   <= '0;
        r_utag[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_status[i] <= w_status_nxt[i];
        if (w_disp && (w_pick == UW'(i))) begin
          r_wdog[i] <= '0;
          r_utag[i] <= r_q_tag[r_rd_ptr];
        end else if (r_state[i] == U_RUN) begin
          r_wdog[i] <= r_wdog[i] + TIMEOUT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpl_ptr       <= '0;
      r_cpl_lock      <= 1'b0;
      r_cpl_lock_unit <= '0;
      r_err_count     <= '0;
      r_interrupt     <= 1'b0;
    end else begin
      r_cpl_lock      <= cpl_valid && !cpl_ready;
      r_cpl_lock_unit <= w_cpl_sel;
      if (w_cpl_hs) begin
        r_cpl_ptr <= f_inc(w_cpl_sel);
        if ((cpl_status != 2'b00) && (r_err_count != 16'hFFFF))
          r_err_count <= r_err_count + 16'd1;
      end
      if (w_cpl_hs && int_en) r_interrupt <= 1'b1;
      else if (int_clear)     r_interrupt <= 1'b0;
    end
  end

endmodule
`default_nettype wire
